cpu_rx_arbiter: RTL and testbench
=================================

Name: cpu_rx_arbiter

Overview:
Packet-granular round-robin arbiter that shares the single CPU-bound AXI-Stream path between C_NUM_PORTS switch ports. It sits upstream of the CPU header insertion stage. It grants one port at a time and holds the grant until that packet's tlast handshake. It forwards that port's data, keep, last and metadata, and stamps the source port index into the tuser metadata so the inserted CPU header identifies the ingress port.

Parameters:
C_DATA_WIDTH, 256, tdata width in bits (tkeep = C_DATA_WIDTH/8).
C_TUSER_WIDTH, 128, per-packet metadata width.
C_NUM_PORTS, 4, number of requesting ports (2..16).
C_SRC_PORT_LSB, 16, LSB of the tuser field overwritten with the source port index.

Ports:
clk  in  1  single clock.
rst  in  1  synchronous active-high reset.
s_axis_tdata  in  C_NUM_PORTS*C_DATA_WIDTH  flattened; port i at [i*C_DATA_WIDTH +: C_DATA_WIDTH].
s_axis_tkeep  in  C_NUM_PORTS*C_DATA_WIDTH/8  flattened, same packing.
s_axis_tuser  in  C_NUM_PORTS*C_TUSER_WIDTH  flattened; must be valid on the first beat and held for the whole packet.
s_axis_tvalid  in  C_NUM_PORTS  per-port valid.
s_axis_tlast  in  C_NUM_PORTS  per-port last.
s_axis_tready  out  C_NUM_PORTS  per-port ready.
m_axis_tdata  out  C_DATA_WIDTH  granted port's data.
m_axis_tkeep  out  C_DATA_WIDTH/8  granted port's keep.
m_axis_tuser  out  C_TUSER_WIDTH  granted port's tuser with the source index inserted.
m_axis_tvalid  out  1  valid toward the header stage.
m_axis_tlast  out  1  last toward the header stage.
m_axis_tready  in  1  ready from the header stage.
grant_idx  out  IDX_W  currently granted port. IDX_W = clog2(C_NUM_PORTS), minimum 1.
busy  out  1  high while a packet is granted.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): state=IDLE; last_grant=C_NUM_PORTS-1, so port 0 has top priority first; grant_idx=0; busy=0. All s_axis_tready=0 and m_axis_tvalid=0 during and after reset.
- States: IDLE, XFER.
- IDLE:
  - If any s_axis_tvalid[i]=1, select the first requesting port scanning last_grant+1, last_grant+2, ... modulo C_NUM_PORTS.
  - Register the selection into grant_idx and go to XFER.
  - No s_axis_tready is asserted in IDLE. Arbitration costs exactly one cycle; latency from tvalid to first m_axis_tvalid is 1 cycle.
- XFER, combinational pass-through of the granted port g=grant_idx:
  - m_axis_tvalid = s_axis_tvalid[g].
  - s_axis_tready[g] = m_axis_tready; all other readies are 0.
  - m_axis_tdata, tkeep, tlast = port g's signals.
  - m_axis_tuser = port g's tuser with bits [C_SRC_PORT_LSB +: IDX_W] replaced by g.
  - When m_axis_tvalid && m_axis_tready && m_axis_tlast: last_grant<=g, go to IDLE.
- Outputs in IDLE: m_axis_tvalid=0, m_axis_tlast=0, data/keep/user driven to 0.
- busy = (state==XFER).
- Boundary conditions:
  - Single requester: that port is granted back-to-back with one IDLE cycle between packets.
  - All ports requesting: strict rotation 0,1,2,3,0...
  - Granted port deasserting tvalid mid-packet (bubble): grant is held, m_axis_tvalid=0, no switch.
  - m_axis_tready=0: all s_axis_tready=0, no beats lost.
  - Single-beat packet (tvalid and tlast on the first beat) is legal and completes in one XFER cycle.
  - Requests from non-granted ports during XFER are ignored until IDLE. The arbiter never drops or reorders beats.
  - rst asserted mid-packet: immediate return to IDLE with priority back at port 0. The upstream partial packet is the upstream block's concern.
- Width rule: C_SRC_PORT_LSB+IDX_W <= C_TUSER_WIDTH. Elaboration fails otherwise.

Decomposition:
- Shared package: state encoding (IDLE=0, XFER=1); IDX_W function (clog2 with minimum 1); C_SRC_PORT_LSB default, shared with the CPU header consumer/parser.
- One natural sub-module: rr_pick.
  - Purely combinational rotating priority encoder.
  - Inputs: request vector, last_grant.
  - Outputs: index, any.
  - Reused by future TX-side arbiters.

Test Plan:
- Reset then single request: port 2 sends a 3-beat packet with tuser=0 -> grant_idx=2 one cycle after tvalid; 3 beats out unchanged; m_axis_tuser[17:16]=2'b10 (bits 16-17); tlast on beat 3; busy drops the next cycle.
- Fairness: all 4 ports continuously send 2-beat packets -> output order of source index 0,1,2,3,0,1 with exactly one idle cycle between packets.
- Backpressure: m_axis_tready toggles 1,0,0,1 during a 4-beat packet from port 1 -> every s_axis_tready equals m_axis_tready for port 1 and is 0 elsewhere; the 4 data words arrive in order with none duplicated.
- Bubble hold: port 0 drops tvalid for 3 cycles mid-packet while port 3 requests -> grant stays 0; port 3 is granted only after port 0's tlast.
- Single-beat packets: port 1 and port 2 each send tvalid=tlast=1 -> two output beats in order 1 then 2, separated by one IDLE cycle.
- Reset mid-packet: assert rst during beat 2 of a port 3 packet -> the next cycle m_axis_tvalid=0 and busy=0; the next grant goes to the lowest requesting index starting at port 0.

Source files
------------

// File: rtl/cpu_rx_arbiter_pkg.sv
// Shared definitions for the CPU-bound receive arbiter and its neighbours.
// The source-port field position is shared with the CPU header parser.
package cpu_rx_arbiter_pkg;

  // Arbiter FSM encoding.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } arb_state_e;

  // Default LSB of the tuser field that carries the ingress port index.
  localparam int SRC_PORT_LSB_DEFAULT = 16;

  // Width of a port index: clog2 of the port count, never less than 1.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cpu_rx_arbiter_rr_pick.sv
// Rotating priority encoder: returns the first set request found when scanning
// upward from the port after last_grant, wrapping modulo N.
module cpu_rx_arbiter_rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  int cand;

  // Scan last_grant+1 .. last_grant+N and keep the first requester.
  always_comb begin
    idx  = '0;
    any  = 1'b0;
    cand = 0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(last_grant) + k) % N;
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/cpu_rx_arbiter.sv
// Packet-granular round-robin arbiter feeding the single CPU-bound stream.
// Handshake: a beat moves on any side only in a cycle where that side's
// tvalid and tready are both high; valid never waits on ready, and while a
// port holds the grant its tready mirrors m_axis_tready regardless of tvalid.
module cpu_rx_arbiter
  import cpu_rx_arbiter_pkg::*;
#(
  parameter int C_DATA_WIDTH   = 256,
  parameter int C_TUSER_WIDTH  = 128,
  parameter int C_NUM_PORTS    = 4,
  parameter int C_SRC_PORT_LSB = SRC_PORT_LSB_DEFAULT
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [C_NUM_PORTS*C_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_NUM_PORTS*C_DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic [C_NUM_PORTS*C_TUSER_WIDTH-1:0]  s_axis_tuser,
  input  logic [C_NUM_PORTS-1:0]                s_axis_tvalid,
  input  logic [C_NUM_PORTS-1:0]                s_axis_tlast,
  output logic [C_NUM_PORTS-1:0]                s_axis_tready,
  output logic [C_DATA_WIDTH-1:0]               m_axis_tdata,
  output logic [C_DATA_WIDTH/8-1:0]             m_axis_tkeep,
  output logic [C_TUSER_WIDTH-1:0]              m_axis_tuser,
  output logic                                  m_axis_tvalid,
  output logic                                  m_axis_tlast,
  input  logic                                  m_axis_tready,
  output logic [idx_w(C_NUM_PORTS)-1:0]         grant_idx,
  output logic                                  busy
);

  localparam int IDX_W = idx_w(C_NUM_PORTS);
  localparam int KW    = C_DATA_WIDTH / 8;

  if (C_NUM_PORTS < 2 || C_NUM_PORTS > 16) begin : g_port_count_check
    $error("cpu_rx_arbiter: C_NUM_PORTS must be 2..16");
  end
  if (C_SRC_PORT_LSB + IDX_W > C_TUSER_WIDTH) begin : g_user_width_check
    $error("cpu_rx_arbiter: source port field does not fit in tuser");
  end

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] last_grant_q, last_grant_d;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  int               gi;

  cpu_rx_arbiter_rr_pick #(
    .N     (C_NUM_PORTS),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req        (s_axis_tvalid),
    .last_grant (last_grant_q),
    .idx        (pick_idx),
    .any        (pick_any)
  );

  // State, grant and round-robin pointer; reset puts port 0 first in line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(C_NUM_PORTS - 1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Next state plus the combinational pass-through of the granted port.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    gi            = int'(grant_q);
    s_axis_tready = '0;
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tuser  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        m_axis_tvalid     = s_axis_tvalid[gi];
        m_axis_tlast      = s_axis_tlast[gi];
        s_axis_tready[gi] = m_axis_tready;
        m_axis_tdata      = s_axis_tdata[gi*C_DATA_WIDTH +: C_DATA_WIDTH];
        m_axis_tkeep      = s_axis_tkeep[gi*KW +: KW];
        m_axis_tuser      = s_axis_tuser[gi*C_TUSER_WIDTH +: C_TUSER_WIDTH];
        m_axis_tuser[C_SRC_PORT_LSB +: IDX_W] = grant_q;
        if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
          last_grant_d = grant_q;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign grant_idx = grant_q;
  assign busy      = (state_q == ST_XFER);

endmodule

// File: tb/tb_cpu_rx_arbiter.sv
// Directed bench for cpu_rx_arbiter: reset, single requester, fairness,
// backpressure, bubble hold, single-beat packets and reset mid-packet.
module tb_cpu_rx_arbiter;

  localparam int N  = 4;
  localparam int W  = 256;
  localparam int KW = W / 8;
  localparam int TU = 128;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*W-1:0]  s_tdata;
  logic [N*KW-1:0] s_tkeep;
  logic [N*TU-1:0] s_tuser;
  logic [N-1:0]    s_tvalid;
  logic [N-1:0]    s_tlast;
  logic [N-1:0]    s_tready;
  logic [W-1:0]    m_tdata;
  logic [KW-1:0]   m_tkeep;
  logic [TU-1:0]   m_tuser;
  logic            m_tvalid;
  logic            m_tlast;
  logic            m_tready;
  logic [IW-1:0]   grant_idx;
  logic            busy;

  int total = 0;
  int bad   = 0;

  cpu_rx_arbiter #(
    .C_DATA_WIDTH   (W),
    .C_TUSER_WIDTH  (TU),
    .C_NUM_PORTS    (N),
    .C_SRC_PORT_LSB (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_tdata),
    .s_axis_tkeep  (s_tkeep),
    .s_axis_tuser  (s_tuser),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tuser  (m_tuser),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tlast  (m_tlast),
    .m_axis_tready (m_tready),
    .grant_idx     (grant_idx),
    .busy          (busy)
  );

  // Clock and watchdog.
  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Data word tagged with port, packet number and beat number.
  function automatic logic [W-1:0] tag(input int p, input int k, input int b);
    logic [W-1:0] t;
    t         = '0;
    t[31:0]   = {8'hA5, p[7:0], k[7:0], b[7:0]};
    t[W-1 -: 8] = 8'h5C;
    return t;
  endfunction

  function automatic logic [KW-1:0] keep_pat(input int p);
    logic [KW-1:0] k;
    k      = {KW{1'b1}};
    k[3:0] = p[3:0];
    return k;
  endfunction

  // Port metadata with ones in bits 17:16 so the index overwrite is visible.
  function automatic logic [TU-1:0] user_pat(input int p);
    logic [TU-1:0] u;
    u        = '0;
    u[31:0]  = 32'h5a53_ab00;
    u[7:0]   = p[7:0];
    u[TU-1 -: 8] = 8'h77;
    return u;
  endfunction

  function automatic logic [TU-1:0] user_exp(input int p);
    logic [TU-1:0] e;
    e        = user_pat(p);
    e[17:16] = p[1:0];
    return e;
  endfunction

  // Driver tasks.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_port(input int p, input logic v, input logic l,
                            input logic [W-1:0] d, input logic [TU-1:0] u);
    s_tvalid[p]           = v;
    s_tlast[p]            = l;
    s_tdata[p*W +: W]     = d;
    s_tkeep[p*KW +: KW]   = keep_pat(p);
    s_tuser[p*TU +: TU]   = u;
  endtask

  task automatic clear_all();
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tuser  = '0;
    s_tvalid = '0;
    s_tlast  = '0;
    m_tready = 1'b1;
  endtask

  task automatic apply_reset();
    clear_all();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_all();
    s_tvalid = '1;
    rst = 1'b1;
    step();
    @(negedge clk);
    total++;
    if ({busy, m_tvalid, m_tlast, grant_idx, s_tready} !== 9'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b exp=0", {busy, m_tvalid, m_tlast, grant_idx, s_tready});
    end
    total++;
    if ({m_tdata, m_tkeep, m_tuser} !== '0) begin
      bad++;
      $display("FAIL reset_data got=%h exp=0", m_tdata);
    end
    step();
    @(negedge clk);
    total++;
    if ({busy, m_tvalid, s_tready} !== 6'b0) begin
      bad++;
      $display("FAIL reset_hold got=%b exp=0", {busy, m_tvalid, s_tready});
    end
    clear_all();
    rst = 1'b0;
  endtask

  task automatic test_single_port();
    apply_reset();
    drive_port(2, 1'b1, 1'b0, tag(2, 0, 0), '0);
    @(negedge clk);
    total++;
    if ({m_tvalid, busy, s_tready} !== 6'b0) begin
      bad++;
      $display("FAIL single_idle got=%b exp=0", {m_tvalid, busy, s_tready});
    end
    step();
    for (int b = 0; b < 3; b++) begin
      drive_port(2, 1'b1, (b == 2), tag(2, 0, b), '0);
      @(negedge clk);
      total++;
      if ({grant_idx, busy, m_tvalid, m_tlast, s_tready} !== {2'd2, 1'b1, 1'b1, (b == 2), 4'b0100}) begin
        bad++;
        $display("FAIL single_ctrl b=%0d got=%b", b, {grant_idx, busy, m_tvalid, m_tlast, s_tready});
      end
      total++;
      if (m_tdata !== tag(2, 0, b) || m_tkeep !== keep_pat(2) || m_tuser !== 128'h2_0000) begin
        bad++;
        $display("FAIL single_data b=%0d got=%h user=%h", b, m_tdata[31:0], m_tuser[31:0]);
      end
      step();
    end
    drive_port(2, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    total++;
    if ({busy, m_tvalid} !== 2'b0 || m_tdata !== '0) begin
      bad++;
      $display("FAIL single_end got=%b exp=00", {busy, m_tvalid});
    end
  endtask

  task automatic test_fairness();
    int pkt [N];
    int beat [N];
    int phase, n;
    logic [IW-1:0] eg;
    apply_reset();
    for (int p = 0; p < N; p++) begin
      pkt[p]  = 0;
      beat[p] = 0;
    end
    for (int c = 0; c < 18; c++) begin
      for (int p = 0; p < N; p++)
        drive_port(p, 1'b1, (beat[p] == 1), tag(p, pkt[p], beat[p]), user_pat(p));
      phase = c % 3;
      n     = c / 3;
      eg    = IW'(n % N);
      @(negedge clk);
      total++;
      if (phase == 0) begin
        if ({m_tvalid, busy, s_tready} !== 6'b0) begin
          bad++;
          $display("FAIL fair_gap c=%0d got=%b exp=0", c, {m_tvalid, busy, s_tready});
        end
      end else begin
        if ({m_tvalid, busy, grant_idx, m_tlast} !== {1'b1, 1'b1, eg, (phase == 2)} ||
            m_tdata !== tag(n % N, n / N, phase - 1) || m_tuser !== user_exp(n % N)) begin
          bad++;
          $display("FAIL fair_beat c=%0d grant=%0d exp=%0d data=%h", c, grant_idx, eg, m_tdata[31:0]);
        end
      end
      for (int p = 0; p < N; p++) begin
        if (s_tready[p] && s_tvalid[p]) begin
          if (beat[p] == 1) begin
            beat[p] = 0;
            pkt[p]++;
          end else begin
            beat[p] = 1;
          end
        end
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    int rdy [8] = '{1, 0, 0, 1, 1, 0, 0, 1};
    int eb [8]  = '{0, 1, 1, 1, 2, 3, 3, 3};
    int beat, rx;
    logic [N-1:0] er;
    apply_reset();
    beat = 0;
    rx   = 0;
    drive_port(1, 1'b1, 1'b0, tag(1, 0, 0), user_pat(1));
    drive_port(3, 1'b1, 1'b0, tag(3, 0, 0), user_pat(3));
    step();
    for (int c = 0; c < 8; c++) begin
      m_tready = 1'(rdy[c]);
      drive_port(1, 1'b1, (beat == 3), tag(1, 0, beat), user_pat(1));
      er = (rdy[c] != 0) ? 4'b0010 : 4'b0000;
      @(negedge clk);
      total++;
      if (s_tready !== er || grant_idx !== 2'd1) begin
        bad++;
        $display("FAIL bp_ready c=%0d got=%b exp=%b", c, s_tready, er);
      end
      total++;
      if (m_tdata !== tag(1, 0, eb[c]) || m_tvalid !== 1'b1) begin
        bad++;
        $display("FAIL bp_data c=%0d got=%h exp=%h", c, m_tdata[31:0], tag(1, 0, eb[c]));
      end
      if (s_tready[1]) begin
        beat++;
        rx++;
      end
      step();
    end
    m_tready = 1'b1;
    drive_port(1, 1'b0, 1'b0, '0, '0);
    drive_port(3, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    total++;
    if (rx !== 4 || busy !== 1'b0) begin
      bad++;
      $display("FAIL bp_count got=%0d busy=%b exp=4 busy=0", rx, busy);
    end
  endtask

  task automatic test_bubble();
    int v [7] = '{1, 0, 0, 0, 1, 1, 1};
    int beat;
    apply_reset();
    beat = 0;
    drive_port(0, 1'b1, 1'b0, tag(0, 0, 0), user_pat(0));
    drive_port(3, 1'b1, 1'b1, tag(3, 0, 0), user_pat(3));
    step();
    for (int c = 0; c < 7; c++) begin
      drive_port(0, 1'(v[c]), (beat == 3), tag(0, 0, beat), user_pat(0));
      @(negedge clk);
      total++;
      if ({grant_idx, busy, m_tvalid, s_tready} !== {2'd0, 1'b1, 1'(v[c]), 4'b0001}) begin
        bad++;
        $display("FAIL bubble_hold c=%0d got=%b", c, {grant_idx, busy, m_tvalid, s_tready});
      end
      if (s_tready[0] && s_tvalid[0]) beat++;
      step();
    end
    drive_port(0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    total++;
    if ({busy, m_tvalid} !== 2'b00 || beat !== 4) begin
      bad++;
      $display("FAIL bubble_end got=%b beats=%0d exp=00 beats=4", {busy, m_tvalid}, beat);
    end
    step();
    @(negedge clk);
    total++;
    if ({grant_idx, m_tvalid, m_tlast} !== {2'd3, 1'b1, 1'b1} || m_tuser !== user_exp(3) ||
        m_tdata !== tag(3, 0, 0)) begin
      bad++;
      $display("FAIL bubble_next got=%0d user=%h exp=3", grant_idx, m_tuser[31:0]);
    end
    step();
    drive_port(3, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL bubble_done busy=%b exp=0", busy);
    end
  endtask

  task automatic test_single_beat();
    apply_reset();
    drive_port(1, 1'b1, 1'b1, tag(1, 0, 0), user_pat(1));
    drive_port(2, 1'b1, 1'b1, tag(2, 0, 0), user_pat(2));
    step();
    @(negedge clk);
    total++;
    if ({grant_idx, m_tvalid, m_tlast} !== {2'd1, 1'b1, 1'b1} || m_tdata !== tag(1, 0, 0)) begin
      bad++;
      $display("FAIL sb_first got=%0d data=%h exp=1", grant_idx, m_tdata[31:0]);
    end
    step();
    drive_port(1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    total++;
    if ({busy, m_tvalid} !== 2'b00) begin
      bad++;
      $display("FAIL sb_gap got=%b exp=00", {busy, m_tvalid});
    end
    step();
    @(negedge clk);
    total++;
    if ({grant_idx, m_tvalid, m_tlast} !== {2'd2, 1'b1, 1'b1} || m_tdata !== tag(2, 0, 0) ||
        m_tuser !== user_exp(2)) begin
      bad++;
      $display("FAIL sb_second got=%0d data=%h exp=2", grant_idx, m_tdata[31:0]);
    end
    step();
    drive_port(2, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL sb_done busy=%b exp=0", busy);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    drive_port(3, 1'b1, 1'b0, tag(3, 0, 0), user_pat(3));
    step();
    @(negedge clk);
    total++;
    if ({grant_idx, m_tvalid} !== {2'd3, 1'b1} || m_tdata !== tag(3, 0, 0)) begin
      bad++;
      $display("FAIL rm_beat0 got=%0d data=%h exp=3", grant_idx, m_tdata[31:0]);
    end
    step();
    drive_port(3, 1'b1, 1'b0, tag(3, 0, 1), user_pat(3));
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (m_tdata !== tag(3, 0, 1) || busy !== 1'b1) begin
      bad++;
      $display("FAIL rm_beat1 got=%h exp=%h", m_tdata[31:0], tag(3, 0, 1));
    end
    step();
    rst = 1'b0;
    drive_port(1, 1'b1, 1'b0, tag(1, 0, 0), user_pat(1));
    @(negedge clk);
    total++;
    if ({m_tvalid, busy, grant_idx, s_tready} !== 8'b0) begin
      bad++;
      $display("FAIL rm_idle got=%b exp=0", {m_tvalid, busy, grant_idx, s_tready});
    end
    step();
    @(negedge clk);
    total++;
    if ({grant_idx, busy, m_tvalid} !== {2'd1, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL rm_regrant got=%0d exp=1", grant_idx);
    end
    clear_all();
  endtask

  // Test sequence and final report.
  initial begin
    clear_all();
    rst = 1'b1;
    test_reset();
    test_single_port();
    test_fairness();
    test_backpressure();
    test_bubble();
    test_single_beat();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
